lc3_mem_responder: RTL and testbench
====================================

// Module: lc3_mem_responder
// PURPOSE
//  Memory-side responder for the LC3 core's memory port: accepts read/write
//  requests, inserts wait states, returns data with a one-cycle READY pulse.
//  Backs a word-addressed RAM plus optional keyboard/display device registers.
//  Sits between the core's MAR/MDR/WE control path and the board I/O.
// PARAMETERS
//  ADDR_W       10  RAM address bits (2^ADDR_W 16-bit words; ADDR aliases modulo size)
//  WAIT_STATES  1   extra cycles between request capture and response (0..15)
// PORTS
//  CLK          in   1   rising-edge clock
//  RESET_N      in   1   asynchronous active-low reset
//  REQ          in   1   request strobe; sampled only in IDLE
//  WE           in   1   1=write, 0=read; sampled with REQ
//  ADDR         in   16  word address; sampled with REQ
//  WDATA        in   16  write data; sampled with REQ
//  RDATA        out  16  read data; valid in the READY cycle, held until next READY
//  READY        out  1   one-cycle completion pulse (reads and writes)
//  BUSY         out  1   1 from the cycle after capture until after the READY cycle
//  KB_VALID     in   1   one-cycle keyboard character strobe
//  KB_DATA      in   8   keyboard character
//  DISP_DATA    out  8   display character
//  DISP_STROBE  out  1   high while a display character is pending
//  DISP_ACK     in   1   display consumed character
// BEHAVIOUR
//  - Reset: state IDLE, RDATA=0, READY=0, BUSY=0, DISP_DATA=0, DISP_STROBE=0,
//    kb_full=0, wait counter=0. RAM contents not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: REQ=1 latches WE/ADDR/WDATA, cnt<=WAIT_STATES; next WAIT if
//    WAIT_STATES>0 else RESP. REQ=0 stays IDLE.
//    WAIT: cnt decrements; cnt==1 -> RESP.
//    RESP: access performed, READY=1 for this cycle, RDATA updated on reads
//    (unchanged on writes); next IDLE.
//  - Latency: READY rises WAIT_STATES+1 cycles after the REQ-sampling edge.
//    Back-to-back: a REQ in the cycle after READY is accepted (IDLE).
//  - REQ while BUSY ignored (no queueing).
//  - Address map: ADDR < 16'hFE00 -> RAM[ADDR[ADDR_W-1:0]]; >= 16'hFE00 -> I/O.
//    Unmapped I/O reads return 16'h0000; unmapped writes discarded.
//  - Reset mid-transaction: transaction aborted, no RAM/register write, no READY.
// CONFIGURATION
//  LC3_MMIO_EN defined:
//   KBSR FE00 read {kb_full,15'b0}; writes ignored.
//   KBDR FE02 read {8'h00,kb_char}; the read clears kb_full in the RESP cycle.
//   KB_VALID with kb_full=0: kb_char<=KB_DATA, kb_full<=1. With kb_full=1:
//   character dropped (old char kept). KB_VALID in same cycle as a KBDR read
//   completes: read returns old char, new char captured, kb_full stays 1.
//   DSR FE04 read {~DISP_STROBE,15'b0}.
//   DDR FE06 write with DISP_STROBE=0: DISP_DATA<=WDATA[7:0], DISP_STROBE<=1;
//   write while DISP_STROBE=1 discarded (READY still pulses).
//   DISP_ACK while DISP_STROBE=1 clears DISP_STROBE next edge; ACK wins over
//   a same-cycle DDR write (write discarded).
//  LC3_MMIO_EN undefined: all addresses >= FE00 unmapped; DISP_STROBE=0,
//   DISP_DATA=0 constant; KB_VALID/KB_DATA/DISP_ACK ignored.
// TESTING
//  1 WAIT_STATES=1: write ADDR=0x0010 WDATA=0x1234, then read 0x0010 ->
//    READY 2 cycles after each REQ edge, RDATA=0x1234, BUSY high 2 cycles.
//  2 WAIT_STATES=0: REQ every other cycle, 4 reads -> READY every 2nd cycle,
//    RDATA matches preloaded RAM; REQ asserted while BUSY -> no extra READY.
//  3 ADDR_W=10: write 0x0405=0xBEEF, read 0x0005 -> 0xBEEF (aliasing).
//  4 MMIO: KB_VALID 'A'(0x41) then 'B' -> KBSR=0x8000, KBDR=0x0041,
//    KBSR then 0x0000; 'B' dropped.
//  5 MMIO: write DDR=0x0048 -> DISP_STROBE=1, DISP_DATA=0x48, DSR=0x0000;
//    second DDR write 0x0049 ignored; DISP_ACK -> DSR=0x8000.
//  6 RESET_N low during WAIT of write 0x0020=0xAAAA -> no READY, outputs at
//    reset values; later read 0x0020 returns prior contents. Without
//    LC3_MMIO_EN: read FE00 -> 0x0000, DISP_STROBE stays 0.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: wait-stated RAM responder for the LC3 memory port (READY pulse per access).
// Keyboard/display registers at FE00-FE06 are present only when LC3_MMIO_EN is defined.
module lc3_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic [7:0]  disp_data,
  output logic        disp_strobe,
  input  logic        disp_ack
);

  // state  | meaning
  // S_IDLE | waiting for req; request fields captured when req is sampled
  // S_WAIT | wait-state countdown; the access happens on the edge leaving cnt==1
  // S_RESP | ready cycle; rdata already holds the read result

  localparam logic [15:0] IO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR    = 16'hFE00;
  localparam logic [15:0] KBDR    = 16'hFE02;
  localparam logic [15:0] DSR     = 16'hFE04;
  localparam logic [15:0] DDR     = 16'hFE06;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [15:0] addr_q, wdata_q;
  logic        access, acc_we, ram_sel;
  logic [15:0] acc_addr, acc_wdata, rd_val, io_rdata;
  logic [15:0] mem [2**ADDR_W];

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_RESP;
            access    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          access    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access coincides with capture, so take the live inputs.
  assign acc_we    = (state == S_IDLE) ? we    : we_q;
  assign acc_addr  = (state == S_IDLE) ? addr  : addr_q;
  assign acc_wdata = (state == S_IDLE) ? wdata : wdata_q;
  assign ram_sel   = (acc_addr < IO_BASE);

  assign ready = (state == S_RESP);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !acc_we) rdata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (access && acc_we && ram_sel && reset_n) mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
  end

  always_comb begin
    rd_val = ram_sel ? mem[acc_addr[ADDR_W-1:0]] : io_rdata;
  end

`ifdef LC3_MMIO_EN
  logic       kb_full;
  logic [7:0] kb_char;
  logic       kb_clr, ddr_wr;

  assign kb_clr = access && !acc_we && (acc_addr == KBDR);
  assign ddr_wr = access &&  acc_we && (acc_addr == DDR);

  always_comb begin
    io_rdata = '0;
    case (acc_addr)
      KBSR:    io_rdata = {kb_full, 15'b0};
      KBDR:    io_rdata = {8'h00, kb_char};
      DSR:     io_rdata = {~disp_strobe, 15'b0};
      default: io_rdata = '0;
    endcase
  end

  // A character arriving on the same edge as a KBDR read refills the emptied buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kb_full <= 1'b0;
      kb_char <= '0;
    end else if (kb_valid && (!kb_full || kb_clr)) begin
      kb_char <= kb_data;
      kb_full <= 1'b1;
    end else if (kb_clr) begin
      kb_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_data   <= '0;
      disp_strobe <= 1'b0;
    end else if (disp_strobe && disp_ack) begin
      disp_strobe <= 1'b0;
    end else if (ddr_wr && !disp_strobe) begin
      disp_data   <= acc_wdata[7:0];
      disp_strobe <= 1'b1;
    end
  end
`else
  logic unused_mmio;

  assign io_rdata    = '0;
  assign disp_data   = '0;
  assign disp_strobe = 1'b0;
  assign unused_mmio = ^{kb_valid, kb_data, disp_ack, KBSR, KBDR, DSR, DDR};
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: three instances (WAIT_STATES 1, 0, 3) checked against
// a word-array memory model, a vector table, and hand sequences for reset and MMIO.
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req [3];
  logic        we [3];
  logic [15:0] addr [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ready [3];
  logic        busy [3];
  logic        kb_valid [3];
  logic [7:0]  kb_data [3];
  logic [7:0]  disp_data [3];
  logic        disp_strobe [3];
  logic        disp_ack [3];

  int ws_of [3] = '{1, 0, 3};
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_ready_cyc = 0;

  logic [15:0] mem_m [3][1024];
  bit          known [3][1024];

  typedef struct {
    int          d;
    bit          w;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc3_mem_responder #(
      .ADDR_W(10),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk(clk), .reset_n(rst_n), .req(req[g]), .we(we[g]), .addr(addr[g]),
      .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]), .busy(busy[g]),
      .kb_valid(kb_valid[g]), .kb_data(kb_data[g]), .disp_data(disp_data[g]),
      .disp_strobe(disp_strobe[g]), .disp_ack(disp_ack[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd);
    logic [15:0] prev;
    int lat, bcnt;
    bit seen;
    prev = rdata[d];
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    tick();
    req[d] = 1'b0;
    lat = 1; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy[d]) bcnt++;
      if (ready[d]) begin
        seen = 1'b1;
        break;
      end
      lat++;
      tick();
    end
    chk("ready_seen", d, 32'(seen), 32'd1);
    rd = 'x;
    if (seen) begin
      last_ready_cyc = cyc;
      chk("latency", d, 32'(lat), 32'(ws_of[d] + 1));
      chk("busy_len", d, 32'(bcnt), 32'(ws_of[d] + 1));
      rd = rdata[d];
      if (w) chk("rdata_hold", d, 32'(rd), 32'(prev));
      tick();
      chk("ready_pulse", d, 32'(ready[d]), 32'd0);
      chk("busy_clear", d, 32'(busy[d]), 32'd0);
    end
  endtask

  // Expected read value from the model; valid=0 where the model has no opinion.
  task automatic model_read(input int d, input logic [15:0] a, output bit valid, output logic [15:0] val);
    int ia;
    ia = int'(a);
    val = '0;
    if (ia < 'hFE00) begin
      valid = known[d][ia % 1024];
      val   = mem_m[d][ia % 1024];
    end else begin
`ifdef LC3_MMIO_EN
      valid = !(ia == 'hFE00 || ia == 'hFE02 || ia == 'hFE04 || ia == 'hFE06);
`else
      valid = 1'b1;
`endif
    end
  endtask

  task automatic txn(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                     output logic [15:0] rd);
    bit valid;
    logic [15:0] ev;
    do_txn(d, w, a, wd, rd);
    if (w) begin
      if (int'(a) < 'hFE00) begin
        mem_m[d][int'(a) % 1024] = wd;
        known[d][int'(a) % 1024] = 1'b1;
      end
    end else begin
      model_read(d, a, valid, ev);
      if (valid) chk("rd_model", d, 32'(rd), 32'(ev));
    end
  endtask

  task automatic busy_req(input int d);
    int n;
    n = 0;
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = 16'h0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ready[d]) n++;
      if (n > 0 && !busy[d]) req[d] = 1'b0;
    end
    req[d] = 1'b0;
    chk("no_queue", d, 32'(n), 32'd1);
  endtask

  task automatic kb_pulse(input int d, input logic [7:0] ch);
    kb_valid[d] = 1'b1; kb_data[d] = ch;
    tick();
    kb_valid[d] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    for (int d = 0; d < 3; d++) begin
      chk({name, "_rdata"}, d, 32'(rdata[d]), 32'd0);
      chk({name, "_ready"}, d, 32'(ready[d]), 32'd0);
      chk({name, "_busy"}, d, 32'(busy[d]), 32'd0);
      chk({name, "_dstrobe"}, d, 32'(disp_strobe[d]), 32'd0);
      chk({name, "_ddata"}, d, 32'(disp_data[d]), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] rd;
    int d, n;
    bit w;
    logic [15:0] a;

    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      kb_valid[i] = 1'b0; kb_data[i] = '0; disp_ack[i] = 1'b0;
    end

    vt.push_back('{0, 1'b1, 16'h0010, 16'h1234, 16'h0000});
    vt.push_back('{0, 1'b0, 16'h0010, 16'h0000, 16'h1234});
    vt.push_back('{0, 1'b1, 16'h0405, 16'hBEEF, 16'h0000});
    vt.push_back('{0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF});
    vt.push_back('{0, 1'b1, 16'hFDFF, 16'h7777, 16'h0000});
    vt.push_back('{0, 1'b0, 16'h01FF, 16'h0000, 16'h7777});
    vt.push_back('{0, 1'b1, 16'hFE10, 16'hDEAD, 16'h0000});
    vt.push_back('{0, 1'b0, 16'h0010, 16'h0000, 16'h1234});
    vt.push_back('{0, 1'b0, 16'hFE00, 16'h0000, 16'h0000});
    vt.push_back('{0, 1'b1, 16'hFE00, 16'hFFFF, 16'h0000});
    vt.push_back('{0, 1'b0, 16'hFE00, 16'h0000, 16'h0000});
    vt.push_back('{0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000});
    vt.push_back('{1, 1'b1, 16'h0001, 16'h1111, 16'h0000});
    vt.push_back('{1, 1'b1, 16'h0002, 16'h2222, 16'h0000});
    vt.push_back('{1, 1'b1, 16'h0003, 16'h3333, 16'h0000});
    vt.push_back('{1, 1'b1, 16'h0004, 16'h4444, 16'h0000});
    vt.push_back('{2, 1'b1, 16'h03FF, 16'hCAFE, 16'h0000});
    vt.push_back('{2, 1'b0, 16'h07FF, 16'h0000, 16'hCAFE});
    vt.push_back('{2, 1'b0, 16'hFBFF, 16'h0000, 16'hCAFE});

    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      txn(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, rd);
      if (!vt[i].w) chk("vec_rdata", vt[i].d, 32'(rd), 32'(vt[i].exp));
    end

    for (int k = 1; k <= 4; k++) begin
      n = last_ready_cyc;
      txn(1, 1'b0, 16'(k), 16'h0, rd);
      chk("preload", 1, 32'(rd), 32'(16'(k * 'h1111)));
      if (k > 1) chk("b2b_gap", 1, 32'(last_ready_cyc - n), 32'd2);
    end
    busy_req(1);
    busy_req(2);

`ifdef LC3_MMIO_EN
    kb_pulse(0, 8'h41);
    kb_pulse(0, 8'h42);
    txn(0, 1'b0, 16'hFE00, 16'h0, rd); chk("kbsr_full", 0, 32'(rd), 32'h8000);
    txn(0, 1'b0, 16'hFE02, 16'h0, rd); chk("kbdr_a", 0, 32'(rd), 32'h0041);
    txn(0, 1'b0, 16'hFE00, 16'h0, rd); chk("kbsr_empty", 0, 32'(rd), 32'h0000);
    kb_pulse(1, 8'h43);
    kb_valid[1] = 1'b1; kb_data[1] = 8'h44;
    do_txn(1, 1'b0, 16'hFE02, 16'h0, rd);
    kb_valid[1] = 1'b0;
    chk("kbdr_same_cycle", 1, 32'(rd), 32'h0043);
    txn(1, 1'b0, 16'hFE00, 16'h0, rd); chk("kbsr_refill", 1, 32'(rd), 32'h8000);
    txn(1, 1'b0, 16'hFE02, 16'h0, rd); chk("kbdr_new", 1, 32'(rd), 32'h0044);

    txn(0, 1'b1, 16'hFE06, 16'h0048, rd);
    chk("disp_strobe_set", 0, 32'(disp_strobe[0]), 32'd1);
    chk("disp_data_set", 0, 32'(disp_data[0]), 32'h48);
    txn(0, 1'b0, 16'hFE04, 16'h0, rd); chk("dsr_busy", 0, 32'(rd), 32'h0000);
    txn(0, 1'b1, 16'hFE06, 16'h0049, rd);
    chk("disp_data_kept", 0, 32'(disp_data[0]), 32'h48);
    disp_ack[0] = 1'b1;
    tick();
    disp_ack[0] = 1'b0;
    chk("disp_ack_clear", 0, 32'(disp_strobe[0]), 32'd0);
    txn(0, 1'b0, 16'hFE04, 16'h0, rd); chk("dsr_ready", 0, 32'(rd), 32'h8000);
    txn(1, 1'b1, 16'hFE06, 16'h0050, rd);
    disp_ack[1] = 1'b1;
    do_txn(1, 1'b1, 16'hFE06, 16'h0051, rd);
    disp_ack[1] = 1'b0;
    chk("ack_wins_strobe", 1, 32'(disp_strobe[1]), 32'd0);
    chk("ack_wins_data", 1, 32'(disp_data[1]), 32'h50);
`else
    txn(0, 1'b1, 16'hFE06, 16'h0048, rd);
    chk("nommio_strobe", 0, 32'(disp_strobe[0]), 32'd0);
    chk("nommio_ddata", 0, 32'(disp_data[0]), 32'd0);
    kb_pulse(0, 8'h41);
    txn(0, 1'b0, 16'hFE00, 16'h0, rd); chk("nommio_kbsr", 0, 32'(rd), 32'h0000);
    txn(0, 1'b0, 16'hFE02, 16'h0, rd); chk("nommio_kbdr", 0, 32'(rd), 32'h0000);
`endif

    for (int i = 0; i < 150; i++) begin
      d = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        a = 16'(($urandom_range(0, 62) * 1024) + $urandom_range(0, 7) * 37);
      end else begin
`ifdef LC3_MMIO_EN
        a = 16'($urandom_range('hFE08, 'hFFFF));
`else
        a = 16'($urandom_range('hFE00, 'hFFFF));
`endif
      end
      txn(d, w, a, 16'($urandom), rd);
    end

    txn(0, 1'b1, 16'h0020, 16'h5555, rd);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'hAAAA;
    tick();
    req[0] = 1'b0;
    chk("in_wait", 0, 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ready[0]) n++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ready[0]) n++;
    end
    chk("midrst_no_ready", 0, 32'(n), 32'd0);
    txn(0, 1'b0, 16'h0020, 16'h0, rd);
    chk("midrst_ram_kept", 0, 32'(rd), 32'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
